bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one iteration per clock, with valid/ready handshakes on both sides. It sits directly upstream of the two-digit BCD adder: it converts binary operands into packed BCD, and the adder consumes `bcd[7:0]` as one 8-bit BCD operand. The hundreds digit and an overflow flag let the producer detect values the two-digit adder cannot represent.

---
 rtl/bin_to_bcd_seq.sv | 105 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// One iteration per clock, valid/ready handshake on input and output.
// Optional feature macro: BIN2BCD_OVF_EN -- when defined, ovf flags results
// above 99 (any digit above tens non-zero); when undefined ovf is tied to 0.
// The ovf compare assumes DIGITS >= 3.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int DIG_W = 4 * DIGITS;
  localparam int SR_W  = DIG_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_step;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic [DIG_W-1:0]   bcd_q;

  // Add 3 to every digit field that is 5 or more; no carry between fields.
  function automatic logic [DIG_W-1:0] add3_digits(input logic [DIG_W-1:0] d);
    logic [DIG_W-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // One double-dabble iteration: adjust digits, then shift the whole register.
  assign sr_step = {add3_digits(sr[SR_W-1:BIN_W]), sr[BIN_W-1:0]} << 1;
  assign last    = (cnt == CNT_W'(BIN_W - 1));

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE) && !rst;
  assign bcd       = bcd_q;

  // State register; reset forces IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic for the handshake sequence IDLE -> SHIFT -> DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Working shift register and iteration counter; always reloaded on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sr  <= {{DIG_W{1'b0}}, bin};
      cnt <= '0;
    end else if (state == SHIFT) begin
      sr  <= sr_step;
      cnt <= cnt + 1'b1;
    end
  end

  // Result register: captured on the final iteration, held until the next one.
  always_ff @(posedge clk) begin
    if (rst)                        bcd_q <= '0;
    else if (state == SHIFT && last) bcd_q <= sr_step[SR_W-1:BIN_W];
  end

`ifdef BIN2BCD_OVF_EN
  logic ovf_q;

  // Value exceeds 99 when any digit above the tens digit is non-zero.
  function automatic logic over_99(input logic [DIG_W-1:0] d);
    return |d[DIG_W-1:8];
  endfunction

  // Overflow flag registered alongside the BCD result.
  always_ff @(posedge clk) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (state == SHIFT && last) ovf_q <= over_99(sr_step[SR_W-1:BIN_W]);
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq (default BIN_W=8, DIGITS=3).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  bin = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] bcd;
  logic        ovf;

  int passed = 0;
  int total  = 0;

`ifdef BIN2BCD_OVF_EN
  localparam logic OVF_255 = 1'b1;
`else
  localparam logic OVF_255 = 1'b0;
`endif

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Offer one operand, count edges from the accepting edge (E0 counts as 1)
  // until out_valid is seen at a falling edge. ir is in_ready just after E0.
  task automatic run_conv(input logic [7:0] b, output int edges, output logic ir);
    @(negedge clk);
    bin = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 1;
    @(negedge clk);
    ir = in_ready;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (bcd !== 12'h000) $display("FAIL rst_bcd got=%h exp=000", bcd); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", ovf); else passed++;
    // rst and in_valid together: operand must not be accepted
    bin = 8'd55;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_release_out_valid got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_zero();
    int e; logic ir;
    out_ready = 1'b1;
    run_conv(8'd0, e, ir);
    total++; if (ir !== 1'b0) $display("FAIL zero_in_ready_drop got=%b exp=0", ir); else passed++;
    total++; if (e !== 9) $display("FAIL zero_latency got=%0d exp=9", e); else passed++;
    total++; if (bcd !== 12'h000) $display("FAIL zero_bcd got=%h exp=000", bcd); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL zero_ovf got=%b exp=0", ovf); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL zero_valid_drop got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_values();
    int e; logic ir;
    out_ready = 1'b1;
    run_conv(8'd99, e, ir);
    total++; if (bcd !== 12'h099) $display("FAIL v99_bcd got=%h exp=099", bcd); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL v99_ovf got=%b exp=0", ovf); else passed++;
    run_conv(8'd255, e, ir);
    total++; if (e !== 9) $display("FAIL v255_latency got=%0d exp=9", e); else passed++;
    total++; if (bcd !== 12'h255) $display("FAIL v255_bcd got=%h exp=255", bcd); else passed++;
    total++; if (ovf !== OVF_255) $display("FAIL v255_ovf got=%b exp=%b", ovf, OVF_255); else passed++;
    run_conv(8'd100, e, ir);
    total++; if (bcd !== 12'h100) $display("FAIL v100_bcd got=%h exp=100", bcd); else passed++;
    total++; if (ovf !== OVF_255) $display("FAIL v100_ovf got=%b exp=%b", ovf, OVF_255); else passed++;
    @(negedge clk);
    // result held through IDLE
    total++; if (bcd !== 12'h100) $display("FAIL hold_idle_bcd got=%h exp=100", bcd); else passed++;
  endtask

  task automatic test_backpressure();
    int e; logic ir;
    out_ready = 1'b0;
    run_conv(8'd137, e, ir);
    total++; if (e !== 9) $display("FAIL bp_latency got=%0d exp=9", e); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (bcd !== 12'h137) $display("FAIL bp_bcd_%0d got=%h exp=137", i, bcd); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid_%0d got=%b exp=1", i, out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d got=%b exp=0", i, in_ready); else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop got=%b exp=0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_back got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    int k; int acc_k; int e; logic got1; logic [11:0] r1;
    out_ready = 1'b1;
    @(negedge clk);
    bin = 8'd42;
    in_valid = 1'b1;
    @(posedge clk);
    #1 bin = 8'd58;
    k = 0; acc_k = -1; got1 = 1'b0; r1 = 12'hfff;
    while (acc_k < 0 && k < 30) begin
      @(negedge clk);
      k++;
      if (out_valid && !got1) begin r1 = bcd; got1 = 1'b1; end
      if (in_ready) acc_k = k;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++; if (acc_k !== 10) $display("FAIL b2b_period got=%0d exp=10", acc_k); else passed++;
    total++; if (r1 !== 12'h042) $display("FAIL b2b_first got=%h exp=042", r1); else passed++;
    e = 1;
    @(negedge clk);
    while (!out_valid && e < 40) begin @(negedge clk); e++; end
    total++; if (e !== 9) $display("FAIL b2b_second_latency got=%0d exp=9", e); else passed++;
    total++; if (bcd !== 12'h058) $display("FAIL b2b_second got=%h exp=058", bcd); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int e; logic ir; logic saw_valid; logic nonzero;
    out_ready = 1'b1;
    @(negedge clk);
    bin = 8'd200;
    in_valid = 1'b1;
    @(posedge clk);               // E0 accept
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);    // E1..E4: four SHIFT iterations
    #1 rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    saw_valid = 1'b0; nonzero = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
      if (bcd !== 12'h000 || ovf !== 1'b0) nonzero = 1'b1;
    end
    total++; if (saw_valid !== 1'b0) $display("FAIL mid_rst_no_valid got=%b exp=0", saw_valid); else passed++;
    total++; if (nonzero !== 1'b0) $display("FAIL mid_rst_outputs_zero got=%b exp=0 bcd=%h", nonzero, bcd); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_idle got=%b exp=1", in_ready); else passed++;
    run_conv(8'd7, e, ir);
    total++; if (e !== 9) $display("FAIL after_rst_latency got=%0d exp=9", e); else passed++;
    total++; if (bcd !== 12'h007) $display("FAIL after_rst_bcd got=%h exp=007", bcd); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL after_rst_ovf got=%b exp=0", ovf); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
